// File: rtl/multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_fsm
//
// Main control unit for a multicycle RISC-V style datapath. A Moore FSM walks
// each instruction through FETCH / DECODE / execute / writeback and drives
// the datapath strobes and mux selects from registered decodes of the state.
//
// Parameters
//   MEM_TIMEOUT : consecutive mem_ready-low cycles tolerated in one memory
//                 state before a memory fault (2..255).
//   TRAP_STICKY : 1 = TRAP holds until reset, 0 = TRAP lasts one cycle.
//
// Build option
//   MULTICYCLE_MEM_WAIT_EN : when defined, FETCH/MEMRD/MEMWR wait for
//   mem_ready and an 8-bit stall counter raises mem_fault on timeout. When
//   undefined, mem_ready is ignored and mem_fault is tied low.
//
// Ports
//   clk, reset (sync, active high), opcode[6:0], mem_ready
//   RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond,
//   instr_done (retire pulse), illegal_instr, mem_fault
//   ALUSrcA, ALUSrcB, ALUOp, MemtoReg, PCSource (2 bits each)
//   state_dbg[3:0] : current state encoding
// -----------------------------------------------------------------------------
module multicycle_ctrl_fsm #(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned TRAP_STICKY = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       mem_ready,
   output logic       RegWrite,
   output logic       MemRead,
   output logic       MemWrite,
   output logic       IorD,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCWriteCond,
   output logic       instr_done,
   output logic       illegal_instr,
   output logic       mem_fault,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] ALUOp,
   output logic [1:0] MemtoReg,
   output logic [1:0] PCSource,
   output logic [3:0] state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADDR = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC_R  = 4'd6,
      S_ALUWB   = 4'd7,
      S_BRANCH  = 4'd8,
      S_EXEC_I  = 4'd9,
      S_JAL     = 4'd10,
      S_JALR    = 4'd11,
      S_LUI     = 4'd12,
      S_TRAP    = 4'd13
   } state_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       pc_write_cond;
      logic       instr_done;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] mem_to_reg;
      logic [1:0] pc_source;
   } ctrl_t;

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   // Last counter value that is still tolerated; one more stall means fault.
   localparam logic [7:0] STALL_LIMIT = 8'(MEM_TIMEOUT - 1);

   // Moore decode of the control word for a given state.
   function automatic ctrl_t decode(input state_e s);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.mem_read  = 1'b1;
            c.ir_write  = 1'b1;
            c.pc_write  = 1'b1;
            c.alu_src_b = 2'b01;
         end
         S_DECODE: c.alu_src_b = 2'b10;
         S_MEMADDR: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
         end
         S_MEMRD: begin
            c.mem_read = 1'b1;
            c.iord     = 1'b1;
         end
         S_MEMWB: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b01;
            c.instr_done = 1'b1;
         end
         S_MEMWR: begin
            c.mem_write  = 1'b1;
            c.iord       = 1'b1;
            c.instr_done = 1'b1;
         end
         S_EXEC_R: begin
            c.alu_src_a = 2'b01;
            c.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            c.reg_write  = 1'b1;
            c.instr_done = 1'b1;
         end
         S_BRANCH: begin
            c.alu_src_a     = 2'b01;
            c.alu_op        = 2'b01;
            c.pc_write_cond = 1'b1;
            c.pc_source     = 2'b01;
            c.instr_done    = 1'b1;
         end
         S_EXEC_I: begin
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
            c.alu_op    = 2'b11;
         end
         S_JAL: begin
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.pc_write   = 1'b1;
            c.pc_source  = 2'b01;
            c.instr_done = 1'b1;
         end
         S_JALR: begin
            c.alu_src_a  = 2'b01;
            c.alu_src_b  = 2'b10;
            c.reg_write  = 1'b1;
            c.mem_to_reg = 2'b10;
            c.pc_write   = 1'b1;
            c.instr_done = 1'b1;
         end
         S_LUI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b10;
         end
         default: c = '0;   // TRAP and unused encodings drive no strobes
      endcase
      return c;
   endfunction

   state_e state_q, state_d;
   ctrl_t  ctrl_q;
   logic   illegal_q, illegal_d;
   logic   gate_open;

`ifdef MULTICYCLE_MEM_WAIT_EN
   logic [7:0] stall_cnt_q, stall_cnt_d;
   logic       mem_fault_q, mem_fault_d;
   logic       mem_wait;

   assign mem_wait  = ~mem_ready &
                      ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR));
   // Strobes that commit a memory transfer only fire on the completing cycle.
   assign gate_open = mem_ready | ~((state_q == S_FETCH) || (state_q == S_MEMWR));
`else
   logic [7:0] unused_cfg;

   // mem_ready and the timeout are intentionally not used in this build.
   assign unused_cfg = STALL_LIMIT ^ {7'd0, mem_ready};
   assign gate_open  = 1'b1;
`endif

   always_comb begin
      state_d   = state_q;
      illegal_d = 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
      mem_fault_d = 1'b0;
      stall_cnt_d = '0;   // cleared on mem_ready=1 and on any state change
`endif
      case (state_q)
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADDR;
               OP_R:         state_d = S_EXEC_R;
               OP_I:         state_d = S_EXEC_I;
               OP_BRANCH:    state_d = S_BRANCH;
               OP_JAL:       state_d = S_JAL;
               OP_JALR:      state_d = S_JALR;
               OP_LUI:       state_d = S_LUI;
               default: begin
                  state_d   = S_TRAP;
                  illegal_d = 1'b1;
               end
            endcase
         end
         // Only SW selects the store path; anything else continues as a load.
         S_MEMADDR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:   state_d = S_MEMWB;
         S_EXEC_R, S_EXEC_I, S_LUI: state_d = S_ALUWB;
         S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_JAL, S_JALR: state_d = S_FETCH;
         S_TRAP: begin
            if (TRAP_STICKY != 0) begin
               state_d   = S_TRAP;
               illegal_d = illegal_q;
`ifdef MULTICYCLE_MEM_WAIT_EN
               mem_fault_d = mem_fault_q;
`endif
            end else begin
               state_d = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase
`ifdef MULTICYCLE_MEM_WAIT_EN
      if (mem_wait) begin
         if (stall_cnt_q == STALL_LIMIT) begin
            state_d     = S_TRAP;
            illegal_d   = 1'b0;
            mem_fault_d = 1'b1;
         end else begin
            state_d     = state_q;
            stall_cnt_d = stall_cnt_q + 8'd1;
         end
      end
`endif
   end

   // Control word is registered from the next state so outputs are glitch-free
   // Moore decodes aligned with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_FETCH;
         ctrl_q    <= decode(S_FETCH);
         illegal_q <= 1'b0;
`ifdef MULTICYCLE_MEM_WAIT_EN
         stall_cnt_q <= '0;
         mem_fault_q <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         ctrl_q    <= decode(state_d);
         illegal_q <= illegal_d;
`ifdef MULTICYCLE_MEM_WAIT_EN
         stall_cnt_q <= stall_cnt_d;
         mem_fault_q <= mem_fault_d;
`endif
      end
   end

   assign RegWrite      = ctrl_q.reg_write;
   assign MemRead       = ctrl_q.mem_read;
   assign MemWrite      = ctrl_q.mem_write;
   assign IorD          = ctrl_q.iord;
   assign IRWrite       = ctrl_q.ir_write & gate_open;
   assign PCWrite       = ctrl_q.pc_write & gate_open;
   assign PCWriteCond   = ctrl_q.pc_write_cond;
   assign instr_done    = ctrl_q.instr_done & gate_open;
   assign illegal_instr = illegal_q;
`ifdef MULTICYCLE_MEM_WAIT_EN
   assign mem_fault     = mem_fault_q;
`else
   assign mem_fault     = 1'b0;
`endif
   assign ALUSrcA       = ctrl_q.alu_src_a;
   assign ALUSrcB       = ctrl_q.alu_src_b;
   assign ALUOp         = ctrl_q.alu_op;
   assign MemtoReg      = ctrl_q.mem_to_reg;
   assign PCSource      = ctrl_q.pc_source;
   assign state_dbg     = state_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl_fsm
//
// Two instances share all inputs: g_dut[0] has a sticky TRAP, g_dut[1] a
// one-cycle TRAP. Instructions are issued as opcode sequences; the expected
// state walk of each instruction is a path table built from its opcode, and
// the expected outputs come from a per-state table of asserted controls.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl_fsm;

   localparam int MEM_T = 4;
`ifdef MULTICYCLE_MEM_WAIT_EN
   localparam bit WAIT_EN = 1'b1;
`else
   localparam bit WAIT_EN = 1'b0;
`endif

   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   logic             clk;
   logic             reset;
   logic [6:0]       opcode;
   logic             mem_ready;
   logic [1:0][9:0]  ob;   // 1-bit outputs per instance
   logic [1:0][9:0]  ow;   // 2-bit outputs per instance
   logic [1:0][3:0]  st;

   int tests = 0;
   int fails = 0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      multicycle_ctrl_fsm #(
         .MEM_TIMEOUT(MEM_T),
         .TRAP_STICKY((gi == 0) ? 1 : 0)
      ) u_dut (
         .clk          (clk),
         .reset        (reset),
         .opcode       (opcode),
         .mem_ready    (mem_ready),
         .RegWrite     (ob[gi][0]),
         .MemRead      (ob[gi][1]),
         .MemWrite     (ob[gi][2]),
         .IorD         (ob[gi][3]),
         .IRWrite      (ob[gi][4]),
         .PCWrite      (ob[gi][5]),
         .PCWriteCond  (ob[gi][6]),
         .instr_done   (ob[gi][7]),
         .illegal_instr(ob[gi][8]),
         .mem_fault    (ob[gi][9]),
         .ALUSrcA      (ow[gi][1:0]),
         .ALUSrcB      (ow[gi][3:2]),
         .ALUOp        (ow[gi][5:4]),
         .MemtoReg     (ow[gi][7:6]),
         .PCSource     (ow[gi][9:8]),
         .state_dbg    (st[gi])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected outputs for a state: {PCSource, MemtoReg, ALUOp, ALUSrcB, ALUSrcA, flags}
   // f[0] = illegal cause, f[1] = memory-fault cause (TRAP only).
   function automatic logic [19:0] exp_out(input int s, input logic rdy, input logic [1:0] f);
      logic [9:0] b;
      logic [1:0] sa, sb, op, mr, ps;
      logic       g;
      b = '0; sa = '0; sb = '0; op = '0; mr = '0; ps = '0;
      g = WAIT_EN ? rdy : 1'b1;
      case (s)
         0:  begin b[1] = 1; b[4] = g; b[5] = g; sb = 2'b01; end
         1:  sb = 2'b10;
         2:  begin sa = 2'b01; sb = 2'b10; end
         3:  begin b[1] = 1; b[3] = 1; end
         4:  begin b[0] = 1; mr = 2'b01; b[7] = 1; end
         5:  begin b[2] = 1; b[3] = 1; b[7] = g; end
         6:  begin sa = 2'b01; op = 2'b10; end
         7:  begin b[0] = 1; b[7] = 1; end
         8:  begin sa = 2'b01; op = 2'b01; b[6] = 1; ps = 2'b01; b[7] = 1; end
         9:  begin sa = 2'b01; sb = 2'b10; op = 2'b11; end
         10: begin b[0] = 1; mr = 2'b10; b[5] = 1; ps = 2'b01; b[7] = 1; end
         11: begin sa = 2'b01; sb = 2'b10; b[0] = 1; mr = 2'b10; b[5] = 1; b[7] = 1; end
         12: begin sa = 2'b10; sb = 2'b10; end
         13: begin b[8] = f[0]; b[9] = f[1]; end
         default: b = '0;
      endcase
      return {ps, mr, op, sb, sa, b};
   endfunction

   function automatic bit is_legal(input logic [6:0] o);
      return (o == OP_LW) || (o == OP_SW) || (o == OP_R) || (o == OP_I) ||
             (o == OP_BRANCH) || (o == OP_JAL) || (o == OP_JALR) || (o == OP_LUI);
   endfunction

   function automatic bit is_mem_state(input int s);
      return (s == 0) || (s == 3) || (s == 5);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Drive one cycle of inputs, check both instances (e1 < 0 skips instance 1),
   // then advance to just after the next rising edge.
   task automatic step(input int e0, input int e1, input logic [6:0] opc, input logic rdy,
                       input logic rst, input logic [1:0] f0, input logic [1:0] f1,
                       input string tag);
      reset     = rst;
      opcode    = opc;
      mem_ready = rdy;
      #1;
      check($sformatf("%s/s%0d/state0", tag, e0), 32'(st[0]), 32'(e0));
      check($sformatf("%s/s%0d/out0", tag, e0), 32'({ow[0], ob[0]}), 32'(exp_out(e0, rdy, f0)));
      if (e1 >= 0) begin
         check($sformatf("%s/s%0d/state1", tag, e1), 32'(st[1]), 32'(e1));
         check($sformatf("%s/s%0d/out1", tag, e1), 32'({ow[1], ob[1]}), 32'(exp_out(e1, rdy, f1)));
      end
      @(posedge clk);
      #1;
   endtask

   // Issue one instruction starting in FETCH. n_stall >= 0 forces exactly that
   // many not-ready cycles in MEMRD/MEMWR (none in FETCH); -1 randomizes.
   task automatic run_instr(input logic [6:0] opc, input int n_stall);
      int   path[$];
      int   cyc;
      int   stall;
      logic rdy;
      logic [6:0] drv;
      case (opc)
         OP_LW:     path = '{0, 1, 2, 3, 4};
         OP_SW:     path = '{0, 1, 2, 5};
         OP_R:      path = '{0, 1, 6, 7};
         OP_I:      path = '{0, 1, 9, 7};
         OP_LUI:    path = '{0, 1, 12, 7};
         OP_BRANCH: path = '{0, 1, 8};
         OP_JAL:    path = '{0, 1, 10};
         OP_JALR:   path = '{0, 1, 11};
         default:   path = '{0, 1};
      endcase
      cyc = 0;
      foreach (path[k]) begin
         stall = 0;
         for (int guard = 0; guard < MEM_T + 1; guard++) begin
            if (n_stall >= 0)
               rdy = (path[k] == 0) ? 1'b1 : (stall >= n_stall);
            else if (is_mem_state(path[k]) && stall >= MEM_T - 1)
               rdy = 1'b1;
            else
               rdy = ($urandom_range(0, 2) != 0);
            // Opcode only matters in DECODE/MEMADDR; elsewhere drive noise.
            drv = (path[k] == 1 || path[k] == 2) ? opc : 7'($urandom);
            step(path[k], path[k], drv, rdy, 1'b0, 2'b00, 2'b00, "instr");
            cyc++;
            if (WAIT_EN && is_mem_state(path[k]) && !rdy) stall++;
            else break;
         end
      end
      if (!is_legal(opc)) begin
         step(13, 13, 7'($urandom), 1'b1, 1'b0, 2'b01, 2'b01, "trap_entry");
         step(13, 0,  7'($urandom), 1'b1, 1'b0, 2'b01, 2'b00, "trap_hold");
         step(13, -1, 7'($urandom), 1'b1, 1'b0, 2'b01, 2'b00, "trap_sticky");
         step(13, -1, 7'($urandom), 1'b1, 1'b1, 2'b01, 2'b00, "trap_reset");
         cyc += 4;
      end
      $display("[TB] instr opcode=%b cycles=%0d", opc, cyc);
   endtask

   initial begin
      logic [6:0] legal_ops [8];
      logic [6:0] op;
      legal_ops = '{OP_LW, OP_SW, OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI};
      reset     = 1'b1;
      opcode    = 7'd0;
      mem_ready = 1'b1;
      @(posedge clk);
      #1;
      // Reset held: FETCH decode, no retire/cause flags.
      step(0, 0, 7'h7F, 1'b1, 1'b1, 2'b00, 2'b00, "reset");

      // Directed: LW, BRANCH, JAL, SW with three stalled MEMWR cycles, illegal.
      run_instr(OP_LW, 0);
      run_instr(OP_BRANCH, 0);
      run_instr(OP_JAL, 0);
      run_instr(OP_SW, 3);
      run_instr(7'b1111111, 0);

      // Reset arrives in MEMRD while the memory is stalling.
      step(0, 0, OP_LW, 1'b1, 1'b0, 2'b00, 2'b00, "midstall");
      step(1, 1, OP_LW, 1'b1, 1'b0, 2'b00, 2'b00, "midstall");
      step(2, 2, OP_LW, 1'b1, 1'b0, 2'b00, 2'b00, "midstall");
`ifdef MULTICYCLE_MEM_WAIT_EN
      step(3, 3, 7'($urandom), 1'b0, 1'b0, 2'b00, 2'b00, "midstall");
      step(3, 3, 7'($urandom), 1'b0, 1'b1, 2'b00, 2'b00, "midstall_rst");
      // Counter must restart from zero: exactly MEM_T stalled FETCH cycles.
      for (int k = 0; k < MEM_T; k++)
         step(0, 0, 7'($urandom), 1'b0, 1'b0, 2'b00, 2'b00, "fetch_timeout");
      step(13, 13, 7'($urandom), 1'b1, 1'b0, 2'b10, 2'b10, "memfault_entry");
      step(13, 0,  7'($urandom), 1'b1, 1'b0, 2'b10, 2'b00, "memfault_hold");
      step(13, -1, 7'($urandom), 1'b1, 1'b1, 2'b10, 2'b00, "memfault_reset");
`else
      step(3, 3, 7'($urandom), 1'b0, 1'b1, 2'b00, 2'b00, "midstall_rst");
      step(0, 0, 7'($urandom), 1'b0, 1'b1, 2'b00, 2'b00, "post_rst");
`endif

      // Random instruction stream with random memory readiness.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 8) == 8) begin
            op = 7'($urandom);
            if (is_legal(op)) op = 7'h7F;
         end else begin
            op = legal_ops[$urandom_range(0, 7)];
         end
         run_instr(op, -1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, observed=running expected=finished");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: consecutive mem_ready-low cycles in one memory state before a fault; legal range 2..255.
REQ-002 Parameter TRAP_STICKY, default 1: 1 = TRAP holds until reset; 0 = TRAP lasts one cycle, then FETCH.
REQ-003 Ports: clk in 1 clock; reset in 1 sync active-high reset; opcode in 7 instruction opcode; mem_ready in 1 memory access complete.
REQ-004 Outputs, width 1: RegWrite, MemRead, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, instr_done (one-cycle retire pulse), illegal_instr, mem_fault.
REQ-005 Outputs, width 2: ALUSrcA (00 PC, 01 rs1, 10 zero), ALUSrcB (00 rs2, 01 const 4, 10 imm), ALUOp (00 add, 01 branch compare, 10 R funct, 11 I funct), MemtoReg (00 ALUOut, 01 MDR, 10 PC), PCSource (00 ALU result, 01 ALUOut).
REQ-006 Output state_dbg, width 4: current state encoding.

Function
REQ-007 States and encodings: FETCH 0, DECODE 1, MEMADDR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC_R 6, ALUWB 7, BRANCH 8, EXEC_I 9, JAL 10, JALR 11, LUI 12, TRAP 13; encodings 14-15 SHALL go to FETCH next cycle.
REQ-008 Opcodes: LW 0000011, SW 0100011, R 0110011, I 0010011, BRANCH 1100011, JAL 1101111, JALR 1100111, LUI 0110111.
REQ-009 Transitions: FETCH->DECODE; DECODE->MEMADDR (LW/SW), EXEC_R, EXEC_I, BRANCH, JAL, JALR, LUI per opcode; any other opcode -> TRAP.
REQ-010 Transitions: MEMADDR->MEMRD (LW) or MEMWR (SW); MEMRD->MEMWB; EXEC_R, EXEC_I, LUI -> ALUWB; MEMWB, MEMWR, ALUWB, BRANCH, JAL, JALR -> FETCH.
REQ-011 opcode SHALL be sampled in DECODE and MEMADDR only; changes elsewhere have no effect.
REQ-012 Outputs are Moore decodes of state (plus mem_ready gating per REQ-020); every output not listed for a state is 0.
REQ-013 FETCH: MemRead, IRWrite, PCWrite, ALUSrcB=01. DECODE: ALUSrcB=10. MEMADDR, JALR ALU fields: ALUSrcA=01, ALUSrcB=10, ALUOp=00.
REQ-014 MEMRD: MemRead, IorD. MEMWR: MemWrite, IorD, instr_done. MEMWB: RegWrite, MemtoReg=01, instr_done.
REQ-015 EXEC_R: ALUSrcA=01, ALUOp=10. EXEC_I: ALUSrcA=01, ALUSrcB=10, ALUOp=11. LUI: ALUSrcA=10, ALUSrcB=10. ALUWB: RegWrite, instr_done.
REQ-016 BRANCH: ALUSrcA=01, ALUOp=01, PCWriteCond, PCSource=01, instr_done.
REQ-017 JAL: RegWrite, MemtoReg=10, PCWrite, PCSource=01, instr_done. JALR: REQ-013 ALU fields plus RegWrite, MemtoReg=10, PCWrite, PCSource=00, instr_done.
REQ-018 TRAP: illegal_instr=1 when entered from DECODE; mem_fault=1 when entered by timeout; cause flag held for the whole TRAP residency; all strobes 0.
REQ-019 Latencies without stalls: LW 5, SW 4, R/I/LUI 4, BRANCH/JAL/JALR 3 cycles FETCH-to-FETCH.

Reset
REQ-020 reset high at a clk edge SHALL force FETCH, clear the stall counter and cause flags, from any state including mid-stall and TRAP; reset dominates all other inputs.
REQ-021 During and immediately after reset, outputs equal the FETCH decode; illegal_instr, mem_fault, instr_done = 0.

Configuration
REQ-022 Macro MULTICYCLE_MEM_WAIT_EN defined: FETCH, MEMRD, MEMWR hold while mem_ready=0; MemRead/MemWrite/IorD stay asserted during the hold; IRWrite, PCWrite, instr_done (MEMWR) assert only in the cycle mem_ready=1.
REQ-023 With macro: an 8-bit stall counter clears on entering a memory state and on mem_ready=1, increments per stalled cycle; reaching MEM_TIMEOUT moves to TRAP next cycle with mem_fault.
REQ-024 Macro undefined: mem_ready ignored, memory states last one cycle, no counter logic, mem_fault constant 0.

Verification
REQ-025 Reset, then LW opcode, mem_ready=1: states 0,1,2,3,4,0; RegWrite and MemtoReg=01 only in state 4; one instr_done.
REQ-026 BRANCH then JAL: states 0,1,8,0,1,10,0; PCWriteCond=1 only in 8; PCWrite+PCSource=01+MemtoReg=10 in 10.
REQ-027 Opcode 1111111 in DECODE: state 13, illegal_instr=1; TRAP_STICKY=1 holds until reset; TRAP_STICKY=0 returns to 0 after one cycle.
REQ-028 With macro, SW with mem_ready low 3 cycles in MEMWR: MemWrite high 4 cycles, instr_done only on the 4th.
REQ-029 With macro, MEM_TIMEOUT=4, mem_ready held low in FETCH: TRAP after 4 stalled cycles, mem_fault=1, IRWrite never asserted.
REQ-030 reset asserted in MEMRD mid-stall: next cycle state 0, counter 0, MemRead=1, IorD=0.
